// File: rtl/spi_cmd_pkg.sv
// spi_cmd_pkg: shared opcode, command-word field and FSM state definitions for the SPI command decoder
package spi_cmd_pkg;
    typedef enum logic [3:0] {
        OP_NOP       = 4'd0,
        OP_WRITE     = 4'd1,
        OP_READ      = 4'd2,
        OP_RUN_START = 4'd3,
        OP_RUN_STOP  = 4'd4,
        OP_CLEAR     = 4'd5,
        OP_ERR_CLR   = 4'd6,
        OP_ERR_READ  = 4'd7
    } opcode_e;
    localparam int OP_LSB   = 28;
    localparam int OP_W     = 4;
    localparam int ADDR_LSB = 16;
    localparam int ADDR_FW  = 12;
    localparam int DATA_LSB = 0;
    localparam int DATA_W   = 16;
    typedef enum logic [2:0] {
        S_IDLE,
        S_EXEC,
        S_RD_WAIT,
        S_TX_HI,
        S_TX_LO
    } state_e;
endpackage

// File: rtl/spi_tx_byte_pair.sv
// spi_tx_byte_pair: sends a 16-bit value as two bytes (high first) over a valid/ready handshake
// Ports: clk, rst (async active-low), load/data (start a pair), tx_ready in; tx_byte/tx_valid out.
// A load while a pair is in flight restarts it with the new data.
module spi_tx_byte_pair (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] data,
    input  logic        tx_ready,
    output logic [7:0]  tx_byte,
    output logic        tx_valid
);
    logic [15:0] data_q;
    logic        lo;
    assign tx_byte = lo ? data_q[7:0] : data_q[15:8];
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_q   <= '0;
            lo       <= 1'b0;
            tx_valid <= 1'b0;
        end else if (load) begin
            data_q   <= data;
            lo       <= 1'b0;
            tx_valid <= 1'b1;
        end else if (tx_valid && tx_ready) begin
            lo       <= !lo;
            tx_valid <= !lo;
        end
    end
endmodule

// File: rtl/spi_word_cmd_decoder.sv
// spi_word_cmd_decoder: decodes assembled 32-bit SPI words into parameter-memory writes/reads and run control
// Ports: clk, rst (async active-low); word_in/word_valid command input; mem_* parameter-memory port;
// tx_byte/tx_valid/tx_ready read-back byte stream; run, net_clear, busy, cmd_err status.
// Optional: SPI_CMD_ERR_COUNT_EN adds err_count and opcode 7 (ERR_READ) to read it back.
module spi_word_cmd_decoder
    import spi_cmd_pkg::*;
#(
    parameter int ADDR_W     = 12,
    parameter int RD_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       word_in,
    input  logic              word_valid,
    output logic              mem_wr_en,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wr_data,
    input  logic [15:0]       mem_rd_data,
    output logic [7:0]        tx_byte,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              run,
    output logic              net_clear,
    output logic              busy,
    output logic              cmd_err
`ifdef SPI_CMD_ERR_COUNT_EN
    ,
    output logic [7:0]        err_count
`endif
);
`ifdef SPI_CMD_ERR_COUNT_EN
    localparam logic [3:0] OP_LAST = 4'd7;
`else
    localparam logic [3:0] OP_LAST = 4'd6;
`endif
    localparam logic [2:0] RD_LAT = 3'(RD_LATENCY);
    state_e        state;
    logic [31:0]   word_q;
    logic [2:0]    rd_cnt;
    opcode_e       op;
    logic [11:0]   addr_f;
    logic          bad, ok, err_set, err_clr, tx_load;
    logic [15:0]   tx_data;
    assign op          = opcode_e'(word_q[OP_LSB +: OP_W]);
    assign addr_f      = word_q[ADDR_LSB +: ADDR_FW];
    // address bits beyond the configured memory width must be zero
    assign bad         = (word_q[OP_LSB +: OP_W] > OP_LAST) || ((addr_f >> ADDR_W) != '0);
    assign ok          = state == S_EXEC && !bad;
    assign mem_wr_en   = ok && op == OP_WRITE;
    assign mem_rd_en   = ok && op == OP_READ;
    assign net_clear   = ok && op == OP_CLEAR;
    assign mem_addr    = word_q[ADDR_LSB +: ADDR_W];
    assign mem_wr_data = word_q[DATA_LSB +: DATA_W];
    assign busy        = state != S_IDLE;
    assign err_set     = (state == S_EXEC && bad) || (word_valid && busy);
    assign err_clr     = ok && op == OP_ERR_CLR;
    assign tx_load     = (state == S_RD_WAIT && rd_cnt == RD_LAT) || (ok && op == OP_ERR_READ);
`ifdef SPI_CMD_ERR_COUNT_EN
    assign tx_data     = state == S_EXEC ? {8'h00, err_count} : mem_rd_data;
    // an error raised in the same cycle as ERR_CLR survives the clear
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            err_count <= '0;
        else if (err_clr)
            err_count <= err_set ? 8'd1 : 8'd0;
        else if (err_set && err_count != 8'hFF)
            err_count <= err_count + 8'd1;
    end
`else
    assign tx_data     = mem_rd_data;
`endif
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_IDLE;
            word_q  <= '0;
            rd_cnt  <= '0;
            run     <= 1'b0;
            cmd_err <= 1'b0;
        end else begin
            cmd_err <= err_set || (cmd_err && !err_clr);
            case (state)
                S_IDLE: begin
                    if (word_valid) begin
                        word_q <= word_in;
                        state  <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    // rd_cnt counts the cycles since mem_rd_en; data is valid at RD_LATENCY
                    rd_cnt <= 3'd1;
                    run    <= ok && op == OP_RUN_START ? 1'b1 : ok && op == OP_RUN_STOP ? 1'b0 : run;
                    state  <= mem_rd_en ? S_RD_WAIT : tx_load ? S_TX_HI : S_IDLE;
                end
                S_RD_WAIT: begin
                    rd_cnt <= rd_cnt + 3'd1;
                    state  <= rd_cnt == RD_LAT ? S_TX_HI : S_RD_WAIT;
                end
                S_TX_HI: state <= tx_valid && tx_ready ? S_TX_LO : S_TX_HI;
                S_TX_LO: state <= tx_valid && tx_ready ? S_IDLE : S_TX_LO;
                default: state <= S_IDLE;
            endcase
        end
    end
    spi_tx_byte_pair u_tx (
        .clk      (clk),
        .rst      (rst),
        .load     (tx_load),
        .data     (tx_data),
        .tx_ready (tx_ready),
        .tx_byte  (tx_byte),
        .tx_valid (tx_valid)
    );
endmodule

// File: tb/tb_spi_word_cmd_decoder.sv
// tb_spi_word_cmd_decoder: directed table-driven bench for spi_word_cmd_decoder (ADDR_W=8, RD_LATENCY=2)
module tb_spi_word_cmd_decoder;
    localparam int AW = 8;
    localparam int RL = 2;
    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [31:0]   word_in = '0;
    logic          word_valid = 1'b0;
    logic          mem_wr_en, mem_rd_en;
    logic [AW-1:0] mem_addr;
    logic [15:0]   mem_wr_data, mem_rd_data;
    logic [7:0]    tx_byte;
    logic          tx_valid;
    logic          tx_ready = 1'b0;
    logic          run, net_clear, busy, cmd_err;
`ifdef SPI_CMD_ERR_COUNT_EN
    logic [7:0]    err_count;
`endif
    logic [15:0]   p0 = 16'hDEAD, p1 = 16'hDEAD;
    int            checks = 0;
    int            errors = 0;
    always #5 clk = ~clk;
    // memory model: address 0x10 holds 16'h1234, data appears exactly RL cycles after rd_en
    always @(posedge clk) begin
        p0 <= mem_rd_en ? (mem_addr == 8'h10 ? 16'h1234 : 16'h0BAD) : 16'hDEAD;
        p1 <= p0;
    end
    assign mem_rd_data = p1;
    spi_word_cmd_decoder #(.ADDR_W(AW), .RD_LATENCY(RL)) dut (
        .clk         (clk),
        .rst         (rst),
        .word_in     (word_in),
        .word_valid  (word_valid),
        .mem_wr_en   (mem_wr_en),
        .mem_rd_en   (mem_rd_en),
        .mem_addr    (mem_addr),
        .mem_wr_data (mem_wr_data),
        .mem_rd_data (mem_rd_data),
        .tx_byte     (tx_byte),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .run         (run),
        .net_clear   (net_clear),
        .busy        (busy),
        .cmd_err     (cmd_err)
`ifdef SPI_CMD_ERR_COUNT_EN
        ,
        .err_count   (err_count)
`endif
    );
    typedef struct {
        logic [31:0] word;
        logic        wr;
        logic        clr;
        logic [7:0]  addr;
        logic [15:0] data;
        logic        run;
        logic        err;
    } vec_t;
    vec_t v[12];
    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
        end
    endtask
    task automatic step;
        @(posedge clk);
        #1;
    endtask
    // strobe one word; returns in the EXEC cycle
    task automatic send(input logic [31:0] w);
        word_in    = w;
        word_valid = 1'b1;
        step;
        word_valid = 1'b0;
    endtask
    task automatic wait_tx(input string n);
        for (int i = 0; i < 10 && !tx_valid; i++) step;
        chk(n, tx_valid, 1'b1);
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    initial begin
        v[0]  = '{32'h1005ABCD, 1'b1, 1'b0, 8'h05, 16'hABCD, 1'b0, 1'b0};
        v[1]  = '{32'h00000000, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0};
        v[2]  = '{32'h30000000, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b0};
        v[3]  = '{32'h50000000, 1'b0, 1'b1, 8'h00, 16'h0000, 1'b1, 1'b0};
        v[4]  = '{32'h40000000, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0};
        v[5]  = '{32'hF0001234, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b1};
        v[6]  = '{32'h60000000, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0};
        v[7]  = '{32'h11005555, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b1};
        v[8]  = '{32'h60000000, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0};
        v[9]  = '{32'h10FF0001, 1'b1, 1'b0, 8'hFF, 16'h0001, 1'b0, 1'b0};
        v[10] = '{32'h8000FFFF, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b1};
        v[11] = '{32'h60000000, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0};
        #12;
        chk("rst_wr_en", mem_wr_en, 1'b0);
        chk("rst_rd_en", mem_rd_en, 1'b0);
        chk("rst_tx_valid", tx_valid, 1'b0);
        chk("rst_run", run, 1'b0);
        chk("rst_net_clear", net_clear, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_cmd_err", cmd_err, 1'b0);
        @(posedge clk);
        #1 rst = 1'b1;
        step;
        for (int i = 0; i < 12; i++) begin
            send(v[i].word);
            chk($sformatf("v%0d_wr_en", i), mem_wr_en, v[i].wr);
            chk($sformatf("v%0d_rd_en", i), mem_rd_en, 1'b0);
            chk($sformatf("v%0d_net_clear", i), net_clear, v[i].clr);
            chk($sformatf("v%0d_busy", i), busy, 1'b1);
            if (v[i].wr) begin
                chk($sformatf("v%0d_addr", i), mem_addr, v[i].addr);
                chk($sformatf("v%0d_data", i), mem_wr_data, v[i].data);
            end
            step;
            chk($sformatf("v%0d_run", i), run, v[i].run);
            chk($sformatf("v%0d_cmd_err", i), cmd_err, v[i].err);
            chk($sformatf("v%0d_wr_en_off", i), mem_wr_en, 1'b0);
            chk($sformatf("v%0d_clear_off", i), net_clear, 1'b0);
            chk($sformatf("v%0d_idle", i), busy, 1'b0);
        end
        // read with back-pressure, plus a word dropped while busy
        send(32'h20100000);
        chk("rd_en", mem_rd_en, 1'b1);
        chk("rd_no_wr", mem_wr_en, 1'b0);
        word_in    = 32'h1020FFFF;
        word_valid = 1'b1;
        step;
        word_valid = 1'b0;
        chk("rd_en_once", mem_rd_en, 1'b0);
        chk("drop_cmd_err", cmd_err, 1'b1);
        step;
        chk("drop_no_wr", mem_wr_en, 1'b0);
        chk("rd_wait_busy", busy, 1'b1);
        wait_tx("rd_tx_valid_hi");
        chk("rd_tx_hi", tx_byte, 8'h12);
        for (int i = 0; i < 3; i++) begin
            step;
            chk("rd_tx_hi_hold", tx_byte, 8'h12);
            chk("rd_tx_valid_hold", tx_valid, 1'b1);
        end
        tx_ready = 1'b1;
        step;
        chk("rd_tx_lo", tx_byte, 8'h34);
        chk("rd_tx_valid_lo", tx_valid, 1'b1);
        step;
        tx_ready = 1'b0;
        chk("rd_tx_done", tx_valid, 1'b0);
        chk("rd_idle", busy, 1'b0);
        send(32'h60000000);
        step;
        chk("errclr_after_drop", cmd_err, 1'b0);
        // asynchronous reset in the middle of the low byte
        send(32'h30000000);
        step;
        send(32'hF0000000);
        step;
        chk("pre_rst_run", run, 1'b1);
        chk("pre_rst_err", cmd_err, 1'b1);
        send(32'h20100000);
        wait_tx("rst_seq_tx_valid");
        tx_ready = 1'b1;
        step;
        tx_ready = 1'b0;
        chk("rst_seq_tx_lo", tx_byte, 8'h34);
        #2 rst = 1'b0;
        #1;
        chk("async_tx_valid", tx_valid, 1'b0);
        chk("async_run", run, 1'b0);
        chk("async_busy", busy, 1'b0);
        chk("async_cmd_err", cmd_err, 1'b0);
        @(posedge clk);
        #1 rst = 1'b1;
        tx_ready = 1'b1;
        send(32'h1033BEEF);
        chk("post_rst_wr_en", mem_wr_en, 1'b1);
        chk("post_rst_addr", mem_addr, 8'h33);
        chk("post_rst_data", mem_wr_data, 16'hBEEF);
        step;
        chk("post_rst_tx_valid", tx_valid, 1'b0);
        chk("post_rst_idle", busy, 1'b0);
        tx_ready = 1'b0;
`ifdef SPI_CMD_ERR_COUNT_EN
        chk("cnt_start", err_count, 8'd0);
        for (int i = 0; i < 3; i++) begin
            send(32'hF0000000);
            step;
        end
        chk("cnt_three", err_count, 8'd3);
        chk("cnt_cmd_err", cmd_err, 1'b1);
        send(32'h70000000);
        chk("err_read_no_rd", mem_rd_en, 1'b0);
        wait_tx("err_read_tx_valid");
        chk("err_read_hi", tx_byte, 8'h00);
        tx_ready = 1'b1;
        step;
        chk("err_read_lo", tx_byte, 8'h03);
        step;
        tx_ready = 1'b0;
        chk("err_read_done", tx_valid, 1'b0);
        send(32'h60000000);
        step;
        chk("cnt_cleared", err_count, 8'd0);
        chk("cnt_cmd_err_clr", cmd_err, 1'b0);
`else
        send(32'h70000000);
        chk("op7_no_rd", mem_rd_en, 1'b0);
        step;
        chk("op7_illegal", cmd_err, 1'b1);
        chk("op7_no_tx", tx_valid, 1'b0);
        chk("op7_idle", busy, 1'b0);
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/spi_word_cmd_decoder.md
Name: spi_word_cmd_decoder

Overview:
- Downstream stage of the SPI 4-byte word assembler.
- Consumes each assembled 32-bit word and decodes it as a command: parameter write, parameter read, network run-control.
- Drives the write/read port of the neuron parameter memory.
- Serialises read-back data as two bytes toward the SPI peripheral transmit path.

Parameters:
- ADDR_W, 12: parameter-memory address width, 1..12; word address field bits above ADDR_W-1 must be zero.
- RD_LATENCY, 1: cycles from rd_en to valid rd_data, 1..4.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset (asserted when 0)
- word_in  in  32  assembled command word
- word_valid  in  1  one-cycle strobe, word_in valid
- mem_wr_en  out  1  memory write strobe
- mem_rd_en  out  1  memory read strobe
- mem_addr  out  ADDR_W  memory address
- mem_wr_data  out  16  memory write data
- mem_rd_data  in  16  memory read data
- tx_byte  out  8  byte offered to SPI tx
- tx_valid  out  1  tx_byte valid
- tx_ready  in  1  SPI tx accepts byte
- run  out  1  network run enable (level)
- net_clear  out  1  one-cycle network state clear pulse
- busy  out  1  decoder not in IDLE
- cmd_err  out  1  sticky error flag

Behaviour:
- Word format: [31:28] opcode, [27:16] address, [15:0] data.
- Opcodes: 0 NOP, 1 WRITE, 2 READ, 3 RUN_START, 4 RUN_STOP, 5 CLEAR, 6 ERR_CLR; others illegal.
- Reset (rst=0, async): all outputs 0, FSM=IDLE.
- FSM states: IDLE, EXEC, RD_WAIT, TX_HI, TX_LO.
- IDLE: on word_valid, latch word_in and go to EXEC next cycle.
- EXEC (1 cycle), by opcode:
  - WRITE: mem_wr_en=1, mem_addr, mem_wr_data driven this cycle -> IDLE.
  - READ: mem_rd_en=1 for one cycle -> RD_WAIT.
  - RUN_START: run<=1 -> IDLE.
  - RUN_STOP: run<=0 -> IDLE.
  - CLEAR: net_clear=1 this cycle only -> IDLE.
  - ERR_CLR: cmd_err<=0 -> IDLE.
  - NOP: no effect -> IDLE.
  - Illegal opcode, or nonzero address bits above ADDR_W-1: no memory access, cmd_err<=1 -> IDLE.
- Write latency: word_valid at cycle N -> mem_wr_en at cycle N+1.
- RD_WAIT: count RD_LATENCY cycles after mem_rd_en, capture mem_rd_data -> TX_HI.
- TX_HI: tx_valid=1, tx_byte=data[15:8]; advance when tx_valid and tx_ready are both high on a clock edge.
- TX_LO: same handshake with data[7:0] -> IDLE.
- tx_byte is stable while tx_valid=1 and not yet accepted.
- busy=1 in every state except IDLE.
- word_valid while busy: word dropped, cmd_err<=1, no other effect.
- word_valid in the same cycle the FSM returns to IDLE: busy is still 1, so the word is dropped.
- Reset during TX: tx_valid drops immediately, byte lost, run cleared.
- cmd_err is sticky: set wins over ERR_CLR only if the error occurs in the same cycle.

Optional Feature:
- Macro: SPI_CMD_ERR_COUNT_EN.
- With it defined:
  - Extra output err_count [7:0] increments on every cmd_err set event, saturating at 255.
  - Reset and ERR_CLR zero the counter.
  - New opcode 7 ERR_READ transmits {8'h00, err_count} via TX_HI/TX_LO, without a memory access.
- Without it: no err_count port; opcode 7 is illegal.

Decomposition:
- Package spi_cmd_pkg:
  - opcode enum (NOP..ERR_READ);
  - field position constants for opcode, address and data;
  - FSM state enum.
- One sub-module, spi_tx_byte_pair: a two-byte valid/ready serialiser for TX_HI/TX_LO, shared with future status-readback blocks.

Test Plan:
- WRITE: word 32'h1_005_ABCD strobed -> next cycle mem_wr_en=1, mem_addr=12'h005, mem_wr_data=16'hABCD, for one cycle only.
- READ, RD_LATENCY=2: word 32'h2_010_0000, memory returns 16'h1234 -> mem_rd_en one cycle, then tx bytes 8'h12 then 8'h34. Hold tx_ready low 3 cycles on the first byte; tx_byte must stay 8'h12.
- Run control: RUN_START -> run=1; CLEAR -> net_clear one-cycle pulse; RUN_STOP -> run=0.
- Errors: opcode 4'hF, or word_valid while busy -> cmd_err=1 and no memory access. ADDR_W=8 with address 12'h100 -> cmd_err=1. ERR_CLR -> cmd_err=0.
- Reset: rst=0 asynchronously mid-TX_LO -> tx_valid, run, busy, cmd_err all 0 immediately. First word after release is decoded normally.
- With SPI_CMD_ERR_COUNT_EN: 3 illegal words, then ERR_READ -> err_count=3, tx bytes 8'h00 then 8'h03.
